// File: rtl/display_responder.sv
// display_responder: buffers CPU display stores in a FIFO and drains one word per DRAIN_CYCLES clocks to the video output, reporting Ready/Busy/Overflow/Count via DSR
module display_responder #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          DDR_Write,
  input  logic [15:0]                   DDR_Data,
  input  logic                          Overflow_Clear,
  output logic [15:0]                   DSR,
  output logic [15:0]                   Data_ToVideo,
  output logic                          Pop_Strobe,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH = FIFO_DEPTH[AW:0];
  localparam logic [DW-1:0] LOAD  = DW'(DRAIN_CYCLES - 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_next;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] drain_cnt, drain_next;
  logic          overflow, full, push, pop;
  assign full = Count == DEPTH;
  assign push = DDR_Write && !full;
  assign Busy = state == HOLD;
  assign DSR  = {!full, Busy, overflow, 10'd0, 3'(Count)};
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    pop        = 1'b0;
    if (state == IDLE) begin
      if (Count != 0) begin
        pop        = 1'b1;
        drain_next = LOAD;
        state_next = HOLD;
      end
    end else if (drain_cnt != 0) begin
      drain_next = drain_cnt - 1'b1;
    end else if (Count != 0) begin
      pop        = 1'b1;
      drain_next = LOAD;
    end else begin
      state_next = IDLE;
    end
  end
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr] <= DDR_Data;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Count        <= '0;
      overflow     <= 1'b0;
      Pop_Strobe   <= 1'b0;
      Data_ToVideo <= 16'h0000;
    end else begin
      state      <= state_next;
      drain_cnt  <= drain_next;
      Pop_Strobe <= pop;
      Count      <= Count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow   <= (DDR_Write && full) || (overflow && !Overflow_Clear);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        Data_ToVideo <= mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_display_responder.sv
// tb_display_responder: directed self-checking bench for display_responder
module tb_display_responder;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        DDR_Write = 1'b0;
  logic [15:0] DDR_Data = 16'h0000;
  logic        Overflow_Clear = 1'b0;
  logic [15:0] DSR, Data_ToVideo;
  logic        Pop_Strobe, Busy;
  logic [2:0]  Count;
  int checks = 0;
  int errors = 0;
  display_responder #(.FIFO_DEPTH(4), .DRAIN_CYCLES(8)) dut (
    .Clk(Clk), .Reset(Reset), .DDR_Write(DDR_Write), .DDR_Data(DDR_Data),
    .Overflow_Clear(Overflow_Clear), .DSR(DSR), .Data_ToVideo(Data_ToVideo),
    .Pop_Strobe(Pop_Strobe), .Busy(Busy), .Count(Count)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] d);
    DDR_Write = 1'b1;
    DDR_Data  = d;
    tick();
    DDR_Write = 1'b0;
  endtask
  task automatic wait_pop(input int n, input logic [15:0] d, input string tag);
    for (int i = 0; i < n - 1; i++) begin
      tick();
      chk({tag, "_nopop"}, {15'd0, Pop_Strobe}, 16'h0000);
    end
    tick();
    chk({tag, "_pop"}, {15'd0, Pop_Strobe}, 16'h0001);
    chk({tag, "_data"}, Data_ToVideo, d);
  endtask
  initial begin
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_dsr", DSR, 16'h8000);
    chk("rst_data", Data_ToVideo, 16'h0000);
    chk("rst_busy", {15'd0, Busy}, 16'h0000);
    chk("rst_count", {13'd0, Count}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_pop", {15'd0, Pop_Strobe}, 16'h0000);
      chk("idle_dsr", DSR, 16'h8000);
    end
    wr(16'h1234);
    chk("single_count", {13'd0, Count}, 16'h0001);
    chk("single_nopop", {15'd0, Pop_Strobe}, 16'h0000);
    chk("single_data0", Data_ToVideo, 16'h0000);
    tick();
    chk("single_data", Data_ToVideo, 16'h1234);
    chk("single_pop", {15'd0, Pop_Strobe}, 16'h0001);
    chk("single_dsr", DSR, 16'hC000);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("single_busy", {15'd0, Busy}, 16'h0001);
      chk("single_pop_low", {15'd0, Pop_Strobe}, 16'h0000);
    end
    tick();
    chk("single_idle", {15'd0, Busy}, 16'h0000);
    chk("single_hold_data", Data_ToVideo, 16'h1234);
    chk("single_count0", {13'd0, Count}, 16'h0000);
    wr(16'hA001);
    chk("burst_first_nopop", {15'd0, Pop_Strobe}, 16'h0000);
    wr(16'hA002);
    chk("burst_first_pop", {15'd0, Pop_Strobe}, 16'h0001);
    chk("burst_first_data", Data_ToVideo, 16'hA001);
    wr(16'hA003);
    wr(16'hA004);
    wr(16'hA005);
    chk("burst_full_count", {13'd0, Count}, 16'h0004);
    chk("burst_full_dsr", DSR, 16'h4004);
    wait_pop(5, 16'hA002, "burst_a002");
    chk("burst_count3", {13'd0, Count}, 16'h0003);
    wait_pop(8, 16'hA003, "burst_a003");
    wait_pop(8, 16'hA004, "burst_a004");
    wait_pop(8, 16'hA005, "burst_a005");
    chk("burst_count0", {13'd0, Count}, 16'h0000);
    for (int i = 0; i < 8; i++) tick();
    chk("burst_end_dsr", DSR, 16'h8000);
    chk("burst_end_data", Data_ToVideo, 16'hA005);
    wr(16'hC001);
    wr(16'hC002);
    wr(16'hC003);
    wr(16'hC004);
    wr(16'hC005);
    chk("ovf_full", {13'd0, Count}, 16'h0004);
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_prepop", {15'd0, Pop_Strobe}, 16'h0000);
    wr(16'hBEEF);
    chk("ovf_pop", {15'd0, Pop_Strobe}, 16'h0001);
    chk("ovf_data", Data_ToVideo, 16'hC002);
    chk("ovf_count", {13'd0, Count}, 16'h0003);
    chk("ovf_dsr", DSR, 16'hE003);
    wr(16'hC006);
    chk("ovf_refill", DSR, 16'h6004);
    DDR_Write = 1'b1;
    DDR_Data = 16'hBEEF;
    Overflow_Clear = 1'b1;
    tick();
    DDR_Write = 1'b0;
    Overflow_Clear = 1'b0;
    chk("clr_set_wins", DSR, 16'h6004);
    Overflow_Clear = 1'b1;
    tick();
    Overflow_Clear = 1'b0;
    chk("clr_bit13", {15'd0, DSR[13]}, 16'h0000);
    chk("clr_dsr", DSR, 16'h4004);
    wait_pop(5, 16'hC003, "drain_c003");
    wait_pop(8, 16'hC004, "drain_c004");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    wr(16'hD001);
    wr(16'hD002);
    chk("rst2_pop", Data_ToVideo, 16'hD001);
    wr(16'hD003);
    tick();
    tick();
    tick();
    chk("rst2_count2", {13'd0, Count}, 16'h0002);
    chk("rst2_busy", {15'd0, Busy}, 16'h0001);
    Reset = 1'b1;
    DDR_Write = 1'b1;
    DDR_Data = 16'hFFFF;
    tick();
    Reset = 1'b0;
    DDR_Write = 1'b0;
    chk("midrst_dsr", DSR, 16'h8000);
    chk("midrst_data", Data_ToVideo, 16'h0000);
    chk("midrst_busy", {15'd0, Busy}, 16'h0000);
    chk("midrst_pop", {15'd0, Pop_Strobe}, 16'h0000);
    wr(16'hE00E);
    chk("post_rst_lat1", Data_ToVideo, 16'h0000);
    tick();
    chk("post_rst_data", Data_ToVideo, 16'hE00E);
    chk("post_rst_pop", {15'd0, Pop_Strobe}, 16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
